if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a credit-limited fetch queue. It issues sequential word reads,
// tracks the single outstanding request and buffers the responses for an in-order consumer.
module if_fetch_queue #(
  parameter int                   BUS_WIDTH     = 64,
  parameter int                   INSTR_WIDTH   = 32,
  parameter int                   INSTR_MEM_LEN = 15,
  parameter int                   FQ_DEPTH      = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_valid,
  input  logic [BUS_WIDTH-1:0]         redirect_pc,
  output logic                         imem_en,
  output logic [INSTR_MEM_LEN-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]       imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUS_WIDTH-1:0]         out_pc,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [$clog2(FQ_DEPTH):0]    fq_count
);

  localparam int PW  = $clog2(FQ_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [BUS_WIDTH-1:0] PC_ALIGN = ~BUS_WIDTH'(3);

  logic [BUS_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [BUS_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic                   inflight_valid_q, inflight_valid_d;
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;

  logic [BUS_WIDTH-1:0]   pc_mem    [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [FQ_DEPTH];

  logic                   head_valid;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic [CW1-1:0]         credit_used;

  // Credits count queued entries plus the outstanding read, so a response always has a slot.
  always_comb begin
    head_valid  = (count_q != '0);
    credit_used = CW1'(count_q) + CW1'(inflight_valid_q) - CW1'(head_valid & out_ready);
    issue       = rst_n & ~redirect_valid & (credit_used < CW1'(FQ_DEPTH));
    push        = inflight_valid_q & ~redirect_valid;
    pop         = head_valid & out_ready & ~redirect_valid;
  end

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = 1'b0;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & PC_ALIGN;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_valid_d = 1'b1;
        inflight_pc_d    = fetch_pc_q;
        fetch_pc_d       = fetch_pc_q + BUS_WIDTH'(4);
      end
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q       <= RESET_PC & PC_ALIGN;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
    end
  end

  // Payload storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= inflight_pc_q;
      instr_mem[tail_q] <= imem_rdata;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q[INSTR_MEM_LEN+1:2];
  assign out_valid = head_valid;
  assign out_pc    = pc_mem[head_q];
  assign out_instr = instr_mem[head_q];
  assign fq_count  = count_q;

endmodule
